// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : RV32I decode stage. Reads the 32x32 register file, sign-extends
//            the immediate and registers the decoded instruction into the
//            ID/EX pipeline register. Also owns the register-file write port
//            driven from writeback.
// Ports    : clk, rst (async, active-low)
//            InstrD, PCD, PCPlus4D, control decoder outputs (D stage)
//            RegWriteW/RDW/ResultW   : writeback write port
//            StallD / FlushE         : hazard unit hold / bubble insertion
//            *E outputs              : registered ID/EX contents
// Config   : REGFILE_BYPASS_EN - when defined, a same-cycle writeback to a
//            register being read is forwarded to the read port.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteD,
  input  logic            ALUSrcD,
  input  logic            MemWriteD,
  input  logic            ResultSrcD,
  input  logic            BranchD,
  input  logic [1:0]      ImmSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            StallD,
  input  logic            FlushE,
  output logic            RegWriteE,
  output logic            ALUSrcE,
  output logic            MemWriteE,
  output logic            ResultSrcE,
  output logic            BranchE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      RS1E,
  output logic [4:0]      RS2E,
  output logic [4:0]      RDE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  logic [XLEN-1:0] rf [NREGS];
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] imm_ext;
  logic            wr_en;

  assign rs1   = InstrD[19:15];
  assign rs2   = InstrD[24:20];
  assign rd    = InstrD[11:7];
  // x0 is never written, so its storage stays at its reset value of zero.
  assign wr_en = RegWriteW && (RDW != 5'd0);

  // Opcode and funct3 are consumed by the control decoder, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{InstrD[6:0], InstrD[14:12]};

  // --------------------------------------------------------------------------
  // Register file: one write port, cleared asynchronously by reset. A write
  // on the same edge that reset is low is discarded.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else if (wr_en) begin
      rf[RDW] <= ResultW;
    end
  end

  // --------------------------------------------------------------------------
  // Combinational reads. x0 is forced to zero on the read side as well so the
  // behaviour never depends on the x0 storage location.
  // --------------------------------------------------------------------------
  always_comb begin
    rd1 = '0;
    rd2 = '0;
`ifdef REGFILE_BYPASS_EN
    if (rs1 != 5'd0) begin
      rd1 = (wr_en && (RDW == rs1)) ? ResultW : rf[rs1];
    end
    if (rs2 != 5'd0) begin
      rd2 = (wr_en && (RDW == rs2)) ? ResultW : rf[rs2];
    end
`else
    // Without the bypass the pre-write value is returned; the hazard unit
    // covers the writeback-to-decode dependency by stalling.
    if (rs1 != 5'd0) begin
      rd1 = rf[rs1];
    end
    if (rs2 != 5'd0) begin
      rd2 = rf[rs2];
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Immediate extension. The reserved encoding 2'b11 decodes as I-type.
  // --------------------------------------------------------------------------
  always_comb begin
    imm_ext = '0;
    unique case (ImmSrcD)
      2'b01:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      2'b10:   imm_ext = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                          InstrD[30:25], InstrD[11:8], 1'b0};
      default: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
    endcase
  end

  // --------------------------------------------------------------------------
  // ID/EX pipeline register. Flush has priority over stall so that a
  // simultaneous request always produces a bubble.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      RS1E        <= '0;
      RS2E        <= '0;
      RDE         <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
    end else if (FlushE) begin
      RegWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      RS1E        <= '0;
      RS2E        <= '0;
      RDE         <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
    end else if (!StallD) begin
      RegWriteE   <= RegWriteD;
      ALUSrcE     <= ALUSrcD;
      MemWriteE   <= MemWriteD;
      ResultSrcE  <= ResultSrcD;
      BranchE     <= BranchD;
      ALUControlE <= ALUControlD;
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= imm_ext;
      RS1E        <= rs1;
      RS2E        <= rs2;
      RDE         <= rd;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Scoreboard bench for decode_stage. Stimulus computes the expected
//            ID/EX contents from an architectural register-file model and
//            queues them; a monitor pops one entry per clock edge and
//            compares it with the DUT outputs. Directed checks cover reset,
//            x0, immediates, stall/flush and the same-cycle write/read case.
// Config   : REGFILE_BYPASS_EN (must match the RTL build)
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  typedef struct packed {
    logic        regwrite;
    logic        alusrc;
    logic        memwrite;
    logic        resultsrc;
    logic        branch;
    logic [2:0]  aluctl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pcplus4;
  } e_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD;
  logic [1:0]  ImmSrcD;
  logic [2:0]  ALUControlD;
  logic        RegWriteW, StallD, FlushE;
  logic [4:0]  RDW;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RS1E, RS2E, RDE;

  decode_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteD(RegWriteD), .ALUSrcD(ALUSrcD), .MemWriteD(MemWriteD),
    .ResultSrcD(ResultSrcD), .BranchD(BranchD), .ImmSrcD(ImmSrcD),
    .ALUControlD(ALUControlD), .RegWriteW(RegWriteW), .RDW(RDW),
    .ResultW(ResultW), .StallD(StallD), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RS1E(RS1E), .RS2E(RS2E),
    .RDE(RDE), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  e_t act;
  assign act = '{RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE,
                 ALUControlE, RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE, PCE, PCPlus4E};

  e_t          q[$];
  e_t          prev;
  e_t          mon_exp;
  logic [31:0] rf_model [32];
  int          n_cmp = 0;
  int          n_err = 0;

  // ---------------- reference model helpers ----------------
  function automatic logic [31:0] model_read(input logic [4:0] rs, input logic wen,
                                             input logic [4:0] wrd, input logic [31:0] wdata);
    if (rs == 0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (wen && wrd == rs) return wdata;
`endif
    return rf_model[rs];
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] ins, input logic [1:0] sel);
    logic signed [11:0] s12;
    logic signed [12:0] s13;
    case (sel)
      2'b01: begin
        s12 = {ins[31:25], ins[11:7]};
        return 32'(int'(s12));
      end
      2'b10: begin
        s13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        return 32'(int'(s13));
      end
      default: return 32'($signed(ins) >>> 20);
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check32(input string name, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_exp = q.pop_front();
      n_cmp++;
      if (act !== mon_exp) begin
        n_err++;
        $display("FAIL vec @%0t: got %h expected %h", $time, act, mon_exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Drives one cycle of inputs (called at edge+2), queues the expected ID/EX
  // contents for the coming edge, updates the model and returns at edge+2.
  task automatic apply(input logic [31:0] ins, input logic [1:0] isrc,
                       input logic [4:0] ctl, input logic [2:0] aluc,
                       input logic wen, input logic [4:0] wrd, input logic [31:0] wdata,
                       input logic stall, input logic flush);
    e_t nv;
    logic [31:0] pc;
    pc = $urandom & 32'hFFFF_FFFC;
    InstrD = ins; ImmSrcD = isrc; PCD = pc; PCPlus4D = pc + 32'd4;
    {RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD} = ctl;
    ALUControlD = aluc;
    RegWriteW = wen; RDW = wrd; ResultW = wdata;
    StallD = stall; FlushE = flush;

    nv.regwrite  = ctl[4];
    nv.alusrc    = ctl[3];
    nv.memwrite  = ctl[2];
    nv.resultsrc = ctl[1];
    nv.branch    = ctl[0];
    nv.aluctl    = aluc;
    nv.rs1       = ins[19:15];
    nv.rs2       = ins[24:20];
    nv.rd        = ins[11:7];
    nv.rd1       = model_read(ins[19:15], wen, wrd, wdata);
    nv.rd2       = model_read(ins[24:20], wen, wrd, wdata);
    nv.imm       = model_imm(ins, isrc);
    nv.pc        = pc;
    nv.pcplus4   = pc + 32'd4;

    if (flush)      prev = '0;
    else if (!stall) prev = nv;
    q.push_back(prev);
    if (wen && wrd != 0) rf_model[wrd] = wdata;
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    q.delete();
    prev = '0;
    for (int i = 0; i < 32; i++) rf_model[i] = 32'd0;
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      apply($urandom, 2'($urandom), 5'($urandom), 3'($urandom),
            1'($urandom), 5'($urandom), $urandom,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end
  endtask

  logic [31:0] s_ins, b_ins, i_ins;

  initial begin
    rst = 1'b0;
    InstrD = '0; PCD = '0; PCPlus4D = '0; ResultW = '0;
    {RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD} = '0;
    ImmSrcD = '0; ALUControlD = '0; RegWriteW = 0; RDW = '0;
    StallD = 0; FlushE = 0;
    model_reset();
    #1;
    check32("reset_outputs_lo", act[31:0], 32'd0);
    check32("reset_outputs_hi", 32'(act >> 32), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;

    // Fill the register file first so later reads see data.
    for (int r = 1; r < 32; r++)
      apply(32'h0000_0013, 2'b00, 5'd0, 3'd0, 1'b1, 5'(r), $urandom, 1'b0, 1'b0);
    random_cycles(300);

    // Asynchronous reset mid-cycle with nonzero state and a coincident write.
    #3;
    rst = 1'b0;
    model_reset();
    RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'hFFFF_FFFF;
    #1;
    check32("async_reset_rd1", RD1E, 32'd0);
    check32("async_reset_pc", PCE, 32'd0);
    check32("async_reset_ctl", {27'd0, RegWriteE, ALUControlE, RDE[0]}, 32'd0);
    @(posedge clk);
    #2;
    check32("reset_held_rde", {27'd0, RDE}, 32'd0);
    RegWriteW = 1'b0;
    rst = 1'b1;

    // x5 reads zero after reset release.
    apply(32'h0002_8013, 2'b00, 5'd0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check32("x5_after_reset", RD1E, 32'd0);

    // Write x5, then read it on both ports.
    apply(32'h0000_0013, 2'b00, 5'd0, 3'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
    apply(32'h0052_8033, 2'b00, 5'b10000, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check32("x5_rd1", RD1E, 32'hDEAD_BEEF);
    check32("x5_rd2", RD2E, 32'hDEAD_BEEF);
    check32("x5_rs1", {27'd0, RS1E}, 32'd5);
    check32("x5_rde", {27'd0, RDE}, 32'd0);

    // Write to x0 is dropped.
    apply(32'h0000_0013, 2'b00, 5'd0, 3'd0, 1'b1, 5'd0, 32'h1234_5678, 1'b0, 1'b0);
    apply(32'h0000_0033, 2'b00, 5'd0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check32("x0_read", RD1E, 32'd0);

    // Immediates.
    i_ins = 32'hFFC0_0093;
    s_ins = {7'h7F, 5'd2, 5'd1, 3'b010, 5'b11000, 7'b0100011};
    b_ins = {1'b0, 6'd0, 5'd2, 5'd1, 3'b000, 4'b1000, 1'b0, 7'b1100011};
    apply(i_ins, 2'b00, 5'd0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check32("imm_i", ImmExtE, 32'hFFFF_FFFC);
    apply(s_ins, 2'b01, 5'd0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check32("imm_s", ImmExtE, 32'hFFFF_FFF8);
    apply(b_ins, 2'b10, 5'd0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check32("imm_b", ImmExtE, 32'h0000_0010);
    apply(i_ins, 2'b11, 5'd0, 3'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check32("imm_reserved", ImmExtE, 32'hFFFF_FFFC);

    // Stall holds, stall+flush produces a bubble.
    apply(32'h0000_0193, 2'b00, 5'b10000, 3'd5, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check32("cap_regwrite", {31'd0, RegWriteE}, 32'd1);
    apply(32'h0010_84B3, 2'b00, 5'b01111, 3'd2, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    check32("stall_regwrite", {31'd0, RegWriteE}, 32'd1);
    check32("stall_aluctl", {29'd0, ALUControlE}, 32'd5);
    check32("stall_rde", {27'd0, RDE}, 32'd3);
    apply(32'h0010_84B3, 2'b00, 5'b11111, 3'd2, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    check32("flush_regwrite", {31'd0, RegWriteE}, 32'd0);
    check32("flush_aluctl", {29'd0, ALUControlE}, 32'd0);
    check32("flush_rde", {27'd0, RDE}, 32'd0);

    // Same-cycle write and read of x7 (x7 is still zero since the reset).
    apply({12'h000, 5'd7, 3'b000, 5'd0, 7'h13}, 2'b00, 5'd0, 3'd0,
          1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 1'b0);
`ifdef REGFILE_BYPASS_EN
    check32("bypass_x7", RD1E, 32'hA5A5_A5A5);
`else
    check32("no_bypass_x7", RD1E, 32'd0);
`endif

    random_cycles(300);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
